// File: rtl/train_sensor_frontend.sv
`default_nettype none
// ============================================================================
// Module   : train_sensor_frontend
// Purpose  : Per-crossing sensor sync/debounce and train-tracking FSM with
//            latched fault handling.
// Revision : 1.0 - initial release
// ============================================================================
module train_sensor_frontend #(
  parameter int NUM_CROSSINGS    = 4,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int CLEAR_CYCLES     = 16,
  parameter int APPROACH_TIMEOUT = 1000,
  parameter int OCCUPY_TIMEOUT   = 2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CROSSINGS-1:0]   approach_raw,
  input  logic [NUM_CROSSINGS-1:0]   exit_raw,
  input  logic [NUM_CROSSINGS-1:0]   fault_clear,
  output logic [NUM_CROSSINGS-1:0]   train_detected,
  output logic [NUM_CROSSINGS-1:0]   train_exited,
  output logic [NUM_CROSSINGS-1:0]   sensor_health,
  output logic [2*NUM_CROSSINGS-1:0] track_states
);

  localparam int C_DCNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_TIMER_W = 24;

  localparam logic [C_DCNT_W-1:0]  C_DCNT_LAST    = C_DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_TIMER_W-1:0] C_APPROACH_LIM = C_TIMER_W'(APPROACH_TIMEOUT);
  localparam logic [C_TIMER_W-1:0] C_OCCUPY_LIM   = C_TIMER_W'(OCCUPY_TIMEOUT);
  localparam logic [C_TIMER_W-1:0] C_CLEAR_LAST   = C_TIMER_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_TRACKING = 2'b01,
    ST_OCCUPIED = 2'b10,
    ST_FAULT    = 2'b11
  } state_t;

  for (genvar ch = 0; ch < NUM_CROSSINGS; ch++) begin : g_chan
    logic [1:0] raw;   // [0] approach, [1] exit
    logic [1:0] deb;
    logic       app_deb;
    logic       exit_deb;

    assign raw = {exit_raw[ch], approach_raw[ch]};

    for (genvar sn = 0; sn < 2; sn++) begin : g_sensor
      logic                s1_q, s2_q, deb_q, deb_d;
      logic [C_DCNT_W-1:0] dcnt_q, dcnt_d;

      always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (s2_q != deb_q) begin
          if (dcnt_q == C_DCNT_LAST) begin
            deb_d = s2_q;
          end else begin
            dcnt_d = dcnt_q + C_DCNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          deb_q  <= 1'b0;
          dcnt_q <= '0;
        end else begin
          s1_q   <= raw[sn];
          s2_q   <= s1_q;
          deb_q  <= deb_d;
          dcnt_q <= dcnt_d;
        end
      end

      assign deb[sn] = deb_q;
    end

    assign app_deb  = deb[0];
    assign exit_deb = deb[1];

    state_t               state_q;
    logic                 clr_phase_q;
    logic                 app_prev_q;
    logic                 det_q;
    logic                 exited_q;
    logic                 health_q;
    logic [C_TIMER_W-1:0] timer_q;

    // Each branch is ordered timeout first, then exit sensor, then approach.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q     <= ST_IDLE;
        clr_phase_q <= 1'b0;
        app_prev_q  <= 1'b0;
        det_q       <= 1'b0;
        exited_q    <= 1'b0;
        health_q    <= 1'b1;
        timer_q     <= '0;
      end else begin
        det_q      <= 1'b0;
        exited_q   <= 1'b0;
        app_prev_q <= app_deb;
        if (timer_q != '1) timer_q <= timer_q + C_TIMER_W'(1);

        case (state_q)
          ST_IDLE: begin
            if (exit_deb) begin
              state_q  <= ST_FAULT;
              health_q <= 1'b0;
              timer_q  <= '0;
            end else if (app_deb && !app_prev_q) begin
              state_q <= ST_TRACKING;
              det_q   <= 1'b1;
              timer_q <= '0;
            end
          end
          ST_TRACKING: begin
            if (timer_q == C_APPROACH_LIM) begin
              state_q  <= ST_FAULT;
              health_q <= 1'b0;
              timer_q  <= '0;
            end else if (exit_deb) begin
              state_q     <= ST_OCCUPIED;
              clr_phase_q <= 1'b0;
              timer_q     <= '0;
            end
          end
          ST_OCCUPIED: begin
            if (!clr_phase_q) begin
              if (timer_q == C_OCCUPY_LIM) begin
                state_q  <= ST_FAULT;
                health_q <= 1'b0;
                timer_q  <= '0;
              end else if (!exit_deb) begin
                clr_phase_q <= 1'b1;
                timer_q     <= '0;
              end
            end else if (exit_deb) begin
              // Gap between wagons: back to counting occupancy.
              clr_phase_q <= 1'b0;
              timer_q     <= '0;
            end else if (timer_q == C_CLEAR_LAST) begin
              state_q     <= ST_IDLE;
              clr_phase_q <= 1'b0;
              exited_q    <= 1'b1;
              timer_q     <= '0;
            end
          end
          ST_FAULT: begin
            clr_phase_q <= 1'b0;
            if (fault_clear[ch] && !app_deb && !exit_deb) begin
              state_q  <= ST_IDLE;
              health_q <= 1'b1;
              timer_q  <= '0;
            end
          end
        endcase
      end
    end

    assign train_detected[ch]     = det_q;
    assign train_exited[ch]       = exited_q;
    assign sensor_health[ch]      = health_q;
    assign track_states[2*ch +: 2] = state_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_train_sensor_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_train_sensor_frontend
// Purpose  : Self-checking bench: directed and randomized train scenarios
//            checked against a timing-formula model of each crossing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_train_sensor_frontend;

  localparam int NCH      = 4;
  localparam int DEB      = 4;
  localparam int CLR      = 16;
  localparam int APP_TO   = 1000;
  localparam int OCC_TO   = 2000;
  // raw edge -> FSM reaction: 2 sync flops, DEB debounce cycles, 1 FSM cycle
  localparam int DET_LAT  = DEB + 3;
  localparam int EXIT_LAT = DEB + 3 + CLR;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     approach_raw;
  logic [NCH-1:0]     exit_raw;
  logic [NCH-1:0]     fault_clear;
  logic [NCH-1:0]     train_detected;
  logic [NCH-1:0]     train_exited;
  logic [NCH-1:0]     sensor_health;
  logic [2*NCH-1:0]   track_states;

  int checks   = 0;
  int failures = 0;

  // Per-channel scenario, times in cycles relative to round start.
  int ar[NCH], ah[NCH], er[NCH], h1[NCH], gp[NCH], h2[NCH];
  bit train[NCH], gapped[NCH];

  train_sensor_frontend #(
    .NUM_CROSSINGS   (NCH),
    .DEBOUNCE_CYCLES (DEB),
    .CLEAR_CYCLES    (CLR),
    .APPROACH_TIMEOUT(APP_TO),
    .OCCUPY_TIMEOUT  (OCC_TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .approach_raw   (approach_raw),
    .exit_raw       (exit_raw),
    .fault_clear    (fault_clear),
    .train_detected (train_detected),
    .train_exited   (train_exited),
    .sensor_health  (sensor_health),
    .track_states   (track_states)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_chan(input int c, input int t, input logic [1:0] st,
                          input logic det, input logic ex, input logic hl);
    chk($sformatf("state ch%0d t=%0d", c, t), 32'(track_states[2*c +: 2]), 32'(st));
    chk($sformatf("detected ch%0d t=%0d", c, t), 32'(train_detected[c]), 32'(det));
    chk($sformatf("exited ch%0d t=%0d", c, t), 32'(train_exited[c]), 32'(ex));
    chk($sformatf("health ch%0d t=%0d", c, t), 32'(sensor_health[c]), 32'(hl));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " detected"}, 32'(train_detected), 32'(0));
    chk({tag, " exited"},   32'(train_exited),   32'(0));
    chk({tag, " health"},   32'(sensor_health),  32'({NCH{1'b1}}));
    chk({tag, " states"},   32'(track_states),   32'(0));
  endtask

  function automatic int fall_of(input int c);
    return gapped[c] ? er[c] + h1[c] + gp[c] + h2[c] : er[c] + h1[c];
  endfunction

  // Channel state as a function of time, straight from the latency rules.
  function automatic logic [1:0] model_state(input int c, input int t);
    if (!train[c] || t < ar[c] + DET_LAT) return 2'b00;
    if (t < er[c] + DET_LAT)              return 2'b01;
    if (t < fall_of(c) + EXIT_LAT)        return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive_round(input int t);
    for (int c = 0; c < NCH; c++) begin
      approach_raw[c] = (t >= ar[c]) && (t < ar[c] + ah[c]);
      exit_raw[c]     = train[c] &&
                        (((t >= er[c]) && (t < er[c] + h1[c])) ||
                         (gapped[c] && (t >= er[c] + h1[c] + gp[c]) && (t < fall_of(c))));
    end
  endtask

  task automatic check_round_cycle(input int t);
    for (int c = 0; c < NCH; c++)
      chk_chan(c, t, model_state(c, t),
               train[c] && (t == ar[c] + DET_LAT),
               train[c] && (t == fall_of(c) + EXIT_LAT), 1'b1);
  endtask

  task automatic run_round();
    int len;
    len = 0;
    for (int c = 0; c < NCH; c++) begin
      int end_t;
      end_t = train[c] ? fall_of(c) + EXIT_LAT : ar[c] + ah[c];
      if (ar[c] + ah[c] > end_t) end_t = ar[c] + ah[c];
      if (end_t > len) len = end_t;
    end
    len += 20;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      check_round_cycle(t);
      drive_round(t);
    end
  endtask

  task automatic clear_scenario();
    for (int c = 0; c < NCH; c++) begin
      train[c] = 1'b0; gapped[c] = 1'b0;
      ar[c] = 0; ah[c] = 0; er[c] = 0; h1[c] = 0; gp[c] = 0; h2[c] = 0;
    end
  endtask

  task automatic set_train(input int c, input int a_rise, input int a_len, input int e_rise,
                           input int e_len, input bit gap, input int g_len, input int e_len2);
    train[c] = 1'b1; ar[c] = a_rise; ah[c] = a_len; er[c] = e_rise; h1[c] = e_len;
    gapped[c] = gap; gp[c] = g_len; h2[c] = e_len2;
  endtask

  initial begin
    rst          = 1'b1;
    approach_raw = '0;
    exit_raw     = '0;
    fault_clear  = '0;
    clear_scenario();

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;

    // Clean pass on ch0, glitch on ch1, wagon gap on ch2
    clear_scenario();
    set_train(0, 0, 50, 50, 100, 1'b0, 0, 0);
    ar[1] = 2; ah[1] = DEB - 1;
    set_train(2, 3, 20, 30, 40, 1'b1, 10, 30);
    run_round();

    // ch0 and ch2 overlapped with a 5-cycle offset
    clear_scenario();
    set_train(0, 0, 30, 20, 60, 1'b0, 0, 0);
    set_train(2, 5, 30, 25, 60, 1'b0, 0, 0);
    run_round();

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      clear_scenario();
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          ar[c] = $urandom_range(0, 10);
          ah[c] = $urandom_range(0, DEB - 1);
        end else begin
          int a0;
          a0 = $urandom_range(0, 10);
          set_train(c, a0, $urandom_range(DEB, 60), a0 + 1 + $urandom_range(0, 40),
                    $urandom_range(DEB, 100), 1'($urandom_range(0, 1)),
                    $urandom_range(DEB, CLR - 1), $urandom_range(DEB, 100));
        end
      end
      run_round();
    end

    // Approach timeout on ch1, exit-without-approach on ch3
    for (int t = 0; t < DET_LAT + APP_TO + 12; t++) begin
      @(negedge clk);
      chk_chan(1, t, (t < DET_LAT) ? 2'b00 : (t < DET_LAT + APP_TO + 1) ? 2'b01 : 2'b11,
               t == DET_LAT, 1'b0, t < DET_LAT + APP_TO + 1);
      chk_chan(3, t, (t < DET_LAT) ? 2'b00 : 2'b11, 1'b0, 1'b0, t < DET_LAT);
      chk_chan(0, t, 2'b00, 1'b0, 1'b0, 1'b1);
      approach_raw[1] = 1'b1;
      exit_raw[3]     = 1'b1;
    end

    // Clear request while sensors still active must be ignored
    fault_clear = 4'b1010;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk_chan(1, t, 2'b11, 1'b0, 1'b0, 1'b0);
      chk_chan(3, t, 2'b11, 1'b0, 1'b0, 1'b0);
    end

    // Sensors drop with clear held: IDLE once both debounced values are low
    for (int t = 0; t < DET_LAT + 8; t++) begin
      @(negedge clk);
      chk_chan(1, t, (t < DET_LAT) ? 2'b11 : 2'b00, 1'b0, 1'b0, t >= DET_LAT);
      chk_chan(3, t, (t < DET_LAT) ? 2'b11 : 2'b00, 1'b0, 1'b0, t >= DET_LAT);
      approach_raw[1] = 1'b0;
      exit_raw[3]     = 1'b0;
    end
    fault_clear = '0;

    // Reset mid-OCCUPIED on ch0 and ch2
    clear_scenario();
    set_train(0, 0, 30, 15, 200, 1'b0, 0, 0);
    set_train(2, 5, 30, 20, 200, 1'b0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      check_round_cycle(t);
      drive_round(t);
    end
    @(negedge clk);
    rst          = 1'b1;
    approach_raw = '0;
    exit_raw     = '0;
    #1;
    chk_reset_values("mid-rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_scenario();
    run_round();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
